// File: rtl/io_hub_pkg.sv
// Shared constants for the PicoBlaze I/O hub: default port map, unmapped read value,
// clock-platform channel indices and a small address-match helper.
package io_hub_pkg;

   localparam logic [7:0] IO_HUB_BASE_IN     = 8'h10;
   localparam logic [7:0] IO_HUB_BASE_OUT    = 8'h40;
   localparam logic [7:0] IO_HUB_STATUS_ADDR = 8'h0F;
   localparam logic [7:0] IO_HUB_RD_UNMAPPED = 8'h00;

   // Input channel map used by the clock firmware
   localparam int unsigned CH_SECONDS   = 0;
   localparam int unsigned CH_MINUTES   = 1;
   localparam int unsigned CH_HOURS     = 2;
   localparam int unsigned CH_DAY       = 3;
   localparam int unsigned CH_MONTH     = 4;
   localparam int unsigned CH_YEAR      = 5;
   localparam int unsigned CH_TMR_SEC   = 6;
   localparam int unsigned CH_TMR_MIN   = 7;
   localparam int unsigned CH_TMR_HOUR  = 8;

   // True when addr selects slot idx of a region starting at base (8-bit wrap).
   function automatic logic addr_hit(input logic [7:0] addr, input logic [7:0] base,
                                     input int unsigned idx);
      return addr == 8'(32'(base) + idx);
   endfunction

endpackage

// File: rtl/io_hub_event_flags.sv
// Sticky event flags: rising-edge detect, read-clear, set wins over a simultaneous clear.
// Edges are ignored on the first cycle after reset so levels held through reset do not flag.
module io_hub_event_flags #(
   parameter int unsigned N_EV = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_EV-1:0] ev_in,
   input  logic            clr,
   output logic [N_EV-1:0] ev_flag
);

   logic [N_EV-1:0] ev_prev_q, ev_prev_d;
   logic [N_EV-1:0] ev_flag_q, ev_flag_d;
   logic            armed_q, armed_d;
   logic [N_EV-1:0] rise;

   always_comb begin
      ev_prev_d = ev_in;
      armed_d   = 1'b1;
      rise      = armed_q ? (ev_in & ~ev_prev_q) : '0;
      ev_flag_d = clr ? rise : (ev_flag_q | rise);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ev_prev_q <= '0;
         ev_flag_q <= '0;
         armed_q   <= 1'b0;
      end else begin
         ev_prev_q <= ev_prev_d;
         ev_flag_q <= ev_flag_d;
         armed_q   <= armed_d;
      end
   end

   assign ev_flag = ev_flag_q;

endmodule

// File: rtl/pb_io_hub.sv
// PicoBlaze port-bus hub: registered input mux, output register file with write pulses,
// sticky event flags. Define IO_HUB_SNAPSHOT_EN for the coherent snapshot group.
module pb_io_hub
   import io_hub_pkg::*;
#(
   parameter int unsigned N_IN        = 12,
   parameter int unsigned N_OUT       = 4,
   parameter int unsigned N_EV        = 4,
   parameter int unsigned SNAP_N      = 3,
   parameter logic [7:0]  BASE_IN     = IO_HUB_BASE_IN,
   parameter logic [7:0]  BASE_OUT    = IO_HUB_BASE_OUT,
   parameter logic [7:0]  STATUS_ADDR = IO_HUB_STATUS_ADDR
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          port_id,
   input  logic                read_strobe,
   input  logic                write_strobe,
   input  logic                k_write_strobe,
   input  logic [7:0]          out_port,
   input  logic [8*N_IN-1:0]   ch_in,
   input  logic [N_EV-1:0]     ev_in,
   output logic [7:0]          in_port,
   output logic [8*N_OUT-1:0]  out_reg,
   output logic [N_OUT-1:0]    wr_pulse
);

   if (N_IN < 1 || N_IN > 32 || N_OUT < 1 || N_OUT > 16 || N_EV < 1 || N_EV > 8 ||
       SNAP_N < 2 || SNAP_N > N_IN) begin : g_bad_cfg
      $error("pb_io_hub: parameter out of range");
   end

   logic [7:0]         in_port_q, in_port_d;
   logic [8*N_OUT-1:0] out_reg_q, out_reg_d;
   logic [N_OUT-1:0]   wr_pulse_q, wr_pulse_d;
   logic [N_EV-1:0]    ev_flag;
   logic               status_clr_c;

   assign status_clr_c = read_strobe && (port_id == STATUS_ADDR);

   io_hub_event_flags #(.N_EV(N_EV)) u_event_flags (
      .clk     (clk),
      .reset   (reset),
      .ev_in   (ev_in),
      .clr     (status_clr_c),
      .ev_flag (ev_flag)
   );

`ifdef IO_HUB_SNAPSHOT_EN
   localparam int unsigned SHADOW_W = 8 * (SNAP_N - 1);

   logic [SHADOW_W-1:0] shadow_q, shadow_d;

   // Reading channel 0 freezes channels 1..SNAP_N-1 so multi-byte fields read coherently
   always_comb begin
      shadow_d = shadow_q;
      if (read_strobe && port_id == BASE_IN) begin
         shadow_d = ch_in[8 +: SHADOW_W];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end
`endif

   // Read mux; later assignments carry higher priority
   always_comb begin
      in_port_d = IO_HUB_RD_UNMAPPED;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (addr_hit(port_id, BASE_IN, i)) begin
            in_port_d = ch_in[8*i +: 8];
         end
      end
`ifdef IO_HUB_SNAPSHOT_EN
      for (int unsigned i = 1; i < SNAP_N; i++) begin
         if (addr_hit(port_id, BASE_IN, i)) begin
            in_port_d = shadow_q[8*(i-1) +: 8];
         end
      end
`endif
      if (port_id == STATUS_ADDR) begin
         in_port_d = 8'(ev_flag);
      end
   end

   // Write decode; a full-address strobe masks the constant-optimised one
   always_comb begin
      out_reg_d  = out_reg_q;
      wr_pulse_d = '0;
      for (int unsigned j = 0; j < N_OUT; j++) begin
         if (write_strobe ? addr_hit(port_id, BASE_OUT, j)
                          : (k_write_strobe && port_id[3:0] == 4'(j))) begin
            out_reg_d[8*j +: 8] = out_port;
            wr_pulse_d[j]       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_port_q  <= '0;
         out_reg_q  <= '0;
         wr_pulse_q <= '0;
      end else begin
         in_port_q  <= in_port_d;
         out_reg_q  <= out_reg_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   assign in_port  = in_port_q;
   assign out_reg  = out_reg_q;
   assign wr_pulse = wr_pulse_q;

endmodule

// File: doc/pb_io_hub.md
# pb_io_hub

Parametrised PicoBlaze I/O hub for the digital clock platform. It owns the processor's input-port read mux, the output register file with per-register write pulses, and a sticky event-flag register. An optional coherent-snapshot group makes multi-byte time/date fields read atomically. It sits between the microcontroller's port bus and the RTC, keyboard and VGA peripherals.

## Interface
- N_IN, 12: number of 8-bit input channels, 1..32
- N_OUT, 4: number of 8-bit output registers, 1..16
- N_EV, 4: number of event inputs, 1..8
- SNAP_N, 3: channels 0..SNAP_N-1 form the snapshot group, 2..N_IN
- BASE_IN, 8'h10: port_id of input channel 0; channel i at BASE_IN+i
- BASE_OUT, 8'h40: port_id of output register 0; register j at BASE_OUT+j
- STATUS_ADDR, 8'h0F: port_id of the event-flag register
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- port_id  in  8  processor port address
- read_strobe  in  1  processor input strobe
- write_strobe  in  1  processor output strobe
- k_write_strobe  in  1  constant-optimised output strobe (decodes port_id[3:0] only)
- out_port  in  8  processor write data
- ch_in  in  8*N_IN  live peripheral values; channel i at [8i+7:8i]
- ev_in  in  N_EV  level event sources, synchronous to clk
- in_port  out  8  registered read data to processor
- out_reg  out  8*N_OUT  output registers, flattened as ch_in
- wr_pulse  out  N_OUT  one-cycle pulse per register write

## Operation
- Read mux: every clk edge, in_port <= value selected by port_id. Mapped: channel i, STATUS_ADDR -> {zero-fill, ev_flag}. Unmapped addresses -> 8'h00 (never X).
- Snapshot (macro on): read_strobe with port_id==BASE_IN loads shadow[1..SNAP_N-1] <= live ch_in at that edge. Reads of channels 1..SNAP_N-1 return shadow; channel 0 and channels >= SNAP_N always live.
- Write decode: write_strobe && port_id==BASE_OUT+j -> out_reg[j] <= out_port, wr_pulse[j]=1 next cycle. k_write_strobe && port_id[3:0]==j (j<N_OUT) does the same. Both strobes high: write_strobe decode wins.
- Event flags: ev_prev registered; rising edge ev_in[k]&~ev_prev[k] sets ev_flag[k]. read_strobe at STATUS_ADDR clears all flags at that edge. Set and clear same edge: set wins.
- Addresses overlapping between regions: priority STATUS_ADDR > input channels > unmapped.

## Timing
- Reset: in_port=0, out_reg=0, wr_pulse=0, ev_flag=0, ev_prev=0, shadow=0.
- Read latency 1 cycle from port_id to in_port; fits PicoBlaze 2-cycle input timing.
- Status read returns pre-clear flags; flag cleared value visible next cycle.
- wr_pulse high exactly one cycle after the strobe edge; out_reg updated same edge as pulse rises.
- Back-to-back writes to same register: pulse each cycle, last data wins.
- Reset mid-operation: all state cleared asynchronously; event edges pending at deassertion are not detected unless ev_in rises after.

## Configuration
- IO_HUB_SNAPSHOT_EN defined: shadow registers and snapshot logic as above.
- Undefined: no shadow registers; all channels read live; SNAP_N ignored.

## Structure
- Package io_hub_pkg: default address constants (BASE_IN, BASE_OUT, STATUS_ADDR), unmapped read value 8'h00, channel index constants for the clock map (seconds, minutes, hours, day, month, year, timer fields).
- Sub-module io_hub_event_flags: edge detect, sticky set, read-clear, set-priority.

## Test plan
- Reset low with ch_in all 8'hA5 -> in_port=0, out_reg=0, wr_pulse=0; after release port_id=8'h12 -> in_port=8'hA5 one cycle later.
- port_id=8'h99 (unmapped) -> in_port=8'h00.
- Macro on: ch0..2=8'h59,8'h59,8'h23; read 8'h10; change ch1 to 8'h00; read 8'h11 -> 8'h59; read 8'h13 tracks live value.
- write_strobe, port_id=8'h42, out_port=8'h3C -> out_reg[2]=8'h3C, wr_pulse=4'b0100 for one cycle; k_write_strobe, port_id=8'hF1 -> register 1 written.
- ev_in[0] rises -> read 8'h0F returns 8'h01, next read 8'h00; rising edge coincident with status read -> flag remains 1.
